stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/stopwatch_ctrl_btn_debounce.sv | 47 ++++
 rtl/stopwatch_ctrl.sv | 137 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control block.
// The state encoding is {adjust, paused}, so next state is assembled from those two bits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    PAUSE     = 2'b01,
    ADJ       = 2'b10,
    ADJ_PAUSE = 2'b11
  } state_t;

  localparam int DEF_DIV_1HZ   = 100_000_000;
  localparam int DEF_DIV_2HZ   = 50_000_000;
  localparam int DEF_DIV_BLINK = 25_000_000;
  localparam int DEF_DB_CYCLES = 1_000_000;

  function automatic logic is_paused(input state_t s);
    return (s == PAUSE) || (s == ADJ_PAUSE);
  endfunction

  function automatic logic is_adj(input state_t s);
    return (s == ADJ) || (s == ADJ_PAUSE);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability-window debounce, and a
// one-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;
  logic          w_sync;

  assign w_sync  = r_sync[1];
  assign o_pulse = r_pulse;

  // The counter tracks how long the synchronized input has disagreed with the
  // debounced level; any return to agreement restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_pulse <= 1'b0;
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= w_sync;
        r_pulse <= w_sync;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM (RUN/PAUSE/ADJ/ADJ_PAUSE) with tick dividers.
// Optional feature macro: STOPWATCH_BLINK_EN enables the adjust-field blink counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV_1HZ   = DEF_DIV_1HZ,
  parameter int DIV_2HZ   = DEF_DIV_2HZ,
  parameter int DIV_BLINK = DEF_DIV_BLINK,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   btn_pause,
  input  logic   btn_rst,
  input  logic   sel_switch,
  input  logic   adj_switch,
  output logic   count_en,
  output logic   clear,
  output logic   adj_mode,
  output logic   adj_sel_min,
  output logic   paused,
  output logic   blink,
  output state_t dbg_state
);

  localparam int DIV_MAX = (DIV_1HZ > DIV_2HZ) ? DIV_1HZ : DIV_2HZ;
  localparam int DW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  if (DIV_1HZ < 1 || DIV_2HZ < 1 || DIV_BLINK < 1 || DB_CYCLES < 1) begin : g_param_check
    $error("stopwatch_ctrl: all divider and debounce parameters must be >= 1");
  end

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_adj_sync;
  logic [1:0]    r_sel_sync;
  logic          w_adj;
  logic          w_pause_pulse;
  logic          w_rst_pulse;
  logic          w_running;
  logic          w_clear;
  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_last;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_pause),
    .o_pulse (w_pause_pulse)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_rst),
    .o_pulse (w_rst_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_adj_sync <= 2'b00;
      r_sel_sync <= 2'b00;
    end else begin
      r_adj_sync <= {r_adj_sync[0], adj_switch};
      r_sel_sync <= {r_sel_sync[0], sel_switch};
    end
  end

  assign w_adj = r_adj_sync[1];

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next;
  end

  // A clear pulse swallows any coincident pause pulse; otherwise the pause
  // toggle and the adjust switch act on independent state bits in one step.
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    if (w_rst_pulse) begin
      w_clear = 1'b1;
      w_next  = w_adj ? ADJ : RUN;
    end else begin
      w_next = state_t'({w_adj, is_paused(r_state) ^ w_pause_pulse});
    end
  end

  assign w_running  = (r_state == RUN) || (r_state == ADJ);
  assign w_div_last = (r_state == ADJ) ? DW'(DIV_2HZ - 1) : DW'(DIV_1HZ - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_clear || (w_next != r_state) || !w_running || (r_div == w_div_last)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  assign count_en    = w_running && (r_div == w_div_last) && !w_clear;
  assign clear       = w_clear;
  assign adj_mode    = is_adj(r_state);
  assign paused      = is_paused(r_state);
  assign adj_sel_min = r_sel_sync[1];
  assign dbg_state   = r_state;

`ifdef STOPWATCH_BLINK_EN
  localparam int BW = (DIV_BLINK > 1) ? $clog2(DIV_BLINK) : 1;

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;

  // Outside adjust (and on a clear) the phase is parked at "on", so the first
  // adjust cycle always shows the field.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (!is_adj(r_state) || w_clear) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == BW'(DIV_BLINK - 1)) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  assign blink = is_adj(r_state) ? r_blink : 1'b1;
`else
  assign blink = 1'b1;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with small divider values.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int DIV_1HZ   = 10;
  localparam int DIV_2HZ   = 5;
  localparam int DIV_BLINK = 3;
  localparam int DB_CYCLES = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   btn_pause = 1'b0;
  logic   btn_rst = 1'b0;
  logic   sel_switch = 1'b0;
  logic   adj_switch = 1'b0;
  logic   count_en, clear, adj_mode, adj_sel_min, paused, blink;
  state_t dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  stopwatch_ctrl #(
    .DIV_1HZ   (DIV_1HZ),
    .DIV_2HZ   (DIV_2HZ),
    .DIV_BLINK (DIV_BLINK),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_pause   (btn_pause),
    .btn_rst     (btn_rst),
    .sel_switch  (sel_switch),
    .adj_switch  (adj_switch),
    .count_en    (count_en),
    .clear       (clear),
    .adj_mode    (adj_mode),
    .adj_sel_min (adj_sel_min),
    .paused      (paused),
    .blink       (blink),
    .dbg_state   (dbg_state)
  );

  // Clock: inputs are driven and outputs sampled on the falling edge.
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sel_switch = 1'b1; adj_switch = 1'b1; btn_pause = 1'b1; btn_rst = 1'b1;
    cycles(4);
    total++; if (count_en !== 1'b0) begin bad++; $display("FAIL reset_count_en got=%b want=0", count_en); end
    total++; if (clear !== 1'b0) begin bad++; $display("FAIL reset_clear got=%b want=0", clear); end
    total++; if (paused !== 1'b0) begin bad++; $display("FAIL reset_paused got=%b want=0", paused); end
    total++; if (adj_mode !== 1'b0) begin bad++; $display("FAIL reset_adj_mode got=%b want=0", adj_mode); end
    total++; if (adj_sel_min !== 1'b0) begin bad++; $display("FAIL reset_adj_sel_min got=%b want=0", adj_sel_min); end
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL reset_blink got=%b want=1", blink); end
    total++; if (dbg_state !== RUN) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, RUN); end
    sel_switch = 1'b0; adj_switch = 1'b0; btn_pause = 1'b0; btn_rst = 1'b0;
    cycles(3);
  endtask

  task automatic test_run_ticks();
    logic exp_en;
    exp_q.delete();
    exp_q.push_back(8'd10); exp_q.push_back(8'd20); exp_q.push_back(8'd30);
    rst = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (c > 1) @(negedge clk);
      exp_en = (exp_q.size() > 0) && (exp_q[0] == 8'(c));
      if (exp_en) void'(exp_q.pop_front());
      total++; if (count_en !== exp_en) begin bad++; $display("FAIL run_count_en cycle=%0d got=%b want=%b", c, count_en, exp_en); end
      total++; if (clear !== 1'b0) begin bad++; $display("FAIL run_clear cycle=%0d got=%b want=0", c, clear); end
      total++; if (paused !== 1'b0) begin bad++; $display("FAIL run_paused cycle=%0d got=%b want=0", c, paused); end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL run_strobes_left got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_pause_hold();
    int toggles, en_paused, t_resume, t_en;
    logic prev;
    toggles = 0; en_paused = 0; prev = paused;
    for (int i = 0; i < 60; i++) begin
      btn_pause = (i < 20);
      @(negedge clk);
      if (paused !== prev) toggles++;
      if (paused === 1'b1 && count_en === 1'b1) en_paused++;
      prev = paused;
    end
    total++; if (toggles != 1) begin bad++; $display("FAIL pause_press_pulses got=%0d want=1", toggles); end
    total++; if (paused !== 1'b1) begin bad++; $display("FAIL pause_paused got=%b want=1", paused); end
    total++; if (dbg_state !== PAUSE) begin bad++; $display("FAIL pause_state got=%0d want=%0d", dbg_state, PAUSE); end
    total++; if (en_paused != 0) begin bad++; $display("FAIL pause_count_en_while_paused got=%0d want=0", en_paused); end

    toggles = 0; t_resume = -1; t_en = -1; prev = paused;
    for (int i = 0; i < 60; i++) begin
      btn_pause = (i < 20);
      @(negedge clk);
      if (paused !== prev) toggles++;
      if (prev === 1'b1 && paused === 1'b0) t_resume = i;
      if (t_resume >= 0 && t_en < 0 && count_en === 1'b1) t_en = i;
      prev = paused;
    end
    total++; if (toggles != 1) begin bad++; $display("FAIL resume_press_pulses got=%0d want=1", toggles); end
    total++; if (paused !== 1'b0) begin bad++; $display("FAIL resume_paused got=%b want=0", paused); end
    total++; if (t_resume < 0 || t_en < 0 || (t_en - t_resume) != 9) begin
      bad++; $display("FAIL resume_first_count_en resume_at=%0d strobe_at=%0d want_gap=9", t_resume, t_en);
    end
  endtask

  task automatic test_glitch();
    state_t s0;
    int errs;
    s0 = dbg_state; errs = 0;
    for (int rep = 0; rep < 5; rep++) begin
      for (int k = 0; k < 6; k++) begin
        btn_pause = (k < 3);
        @(negedge clk);
        total++; if (dbg_state !== s0 || paused !== 1'b0) begin
          bad++; $display("FAIL glitch_state rep=%0d k=%0d got=%0d/%b want=%0d/0", rep, k, dbg_state, paused, s0);
        end
      end
    end
    btn_pause = 1'b0;
    cycles(8);
    total++; if (dbg_state !== s0) begin bad++; $display("FAIL glitch_final_state got=%0d want=%0d", dbg_state, s0); end
  endtask

  task automatic test_adjust();
    logic found, exp_en, exp_bl;
    adj_switch = 1'b1; sel_switch = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (adj_mode === 1'b1) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL adj_entry_timeout got=%b want=1", adj_mode); end
    total++; if (dbg_state !== ADJ) begin bad++; $display("FAIL adj_state got=%0d want=%0d", dbg_state, ADJ); end
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      exp_en = ((c % 5) == 0);
`ifdef STOPWATCH_BLINK_EN
      exp_bl = (((c - 1) / 3) % 2) == 0;
`else
      exp_bl = 1'b1;
`endif
      total++; if (count_en !== exp_en) begin bad++; $display("FAIL adj_count_en cycle=%0d got=%b want=%b", c, count_en, exp_en); end
      total++; if (blink !== exp_bl) begin bad++; $display("FAIL adj_blink cycle=%0d got=%b want=%b", c, blink, exp_bl); end
      total++; if (adj_sel_min !== 1'b1 || adj_mode !== 1'b1 || paused !== 1'b0) begin
        bad++; $display("FAIL adj_flags cycle=%0d sel/adj/paused got=%b%b%b want=110", c, adj_sel_min, adj_mode, paused);
      end
    end
  endtask

  task automatic test_rst_with_pause();
    int n_clear, t_clear, t_en;
    logic found, after;
    adj_switch = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (adj_mode === 1'b0) found = 1'b1;
    end
    total++; if (!found || dbg_state !== RUN) begin bad++; $display("FAIL both_leave_adj got=%0d want=%0d", dbg_state, RUN); end
    btn_pause = 1'b1; cycles(10);
    btn_pause = 1'b0; cycles(10);
    total++; if (dbg_state !== PAUSE) begin bad++; $display("FAIL both_setup_pause got=%0d want=%0d", dbg_state, PAUSE); end

    n_clear = 0; t_clear = -1; t_en = -1; after = 1'b0;
    for (int i = 0; i < 40; i++) begin
      btn_pause = (i < 20); btn_rst = (i < 20);
      @(negedge clk);
      if (after) begin
        after = 1'b0;
        total++; if (dbg_state !== RUN || paused !== 1'b0) begin
          bad++; $display("FAIL both_after_clear state/paused got=%0d/%b want=%0d/0", dbg_state, paused, RUN);
        end
      end
      if (clear === 1'b1) begin
        n_clear++; t_clear = i; after = 1'b1;
        total++; if (count_en !== 1'b0) begin bad++; $display("FAIL both_clear_excl count_en got=%b want=0", count_en); end
      end
      if (t_clear >= 0 && t_en < 0 && count_en === 1'b1) t_en = i;
    end
    total++; if (n_clear != 1) begin bad++; $display("FAIL both_clear_pulses got=%0d want=1", n_clear); end
    total++; if (paused !== 1'b0 || dbg_state !== RUN) begin bad++; $display("FAIL both_final got=%0d/%b want=%0d/0", dbg_state, paused, RUN); end
    total++; if (t_clear < 0 || t_en < 0 || (t_en - t_clear) != 10) begin
      bad++; $display("FAIL both_first_count_en clear_at=%0d strobe_at=%0d want_gap=10", t_clear, t_en);
    end
  endtask

  task automatic test_rst_mid_divide();
    logic found, exp_en;
    found = 1'b0;
    for (int i = 0; i < 15 && !found; i++) begin
      @(negedge clk);
      if (count_en === 1'b1) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL mid_sync_timeout got=%b want=1", count_en); end
    cycles(5);
    btn_pause = 1'b1;
    cycles(3);
    rst = 1'b1; btn_pause = 1'b0;
    @(negedge clk);
    total++; if (count_en !== 1'b0) begin bad++; $display("FAIL mid_count_en got=%b want=0", count_en); end
    total++; if (clear !== 1'b0) begin bad++; $display("FAIL mid_clear got=%b want=0", clear); end
    total++; if (paused !== 1'b0) begin bad++; $display("FAIL mid_paused got=%b want=0", paused); end
    total++; if (adj_mode !== 1'b0) begin bad++; $display("FAIL mid_adj_mode got=%b want=0", adj_mode); end
    total++; if (adj_sel_min !== 1'b0) begin bad++; $display("FAIL mid_adj_sel_min got=%b want=0", adj_sel_min); end
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL mid_blink got=%b want=1", blink); end
    total++; if (dbg_state !== RUN) begin bad++; $display("FAIL mid_state got=%0d want=%0d", dbg_state, RUN); end
    rst = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (c > 1) @(negedge clk);
      exp_en = (c == 10) || (c == 20);
      total++; if (count_en !== exp_en) begin bad++; $display("FAIL mid_restart_count_en cycle=%0d got=%b want=%b", c, count_en, exp_en); end
      total++; if (paused !== 1'b0) begin bad++; $display("FAIL mid_restart_paused cycle=%0d got=%b want=0", c, paused); end
    end
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_pause_hold();
    test_glitch();
    test_adjust();
    test_rst_with_pause();
    test_rst_mid_divide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
